pwm_comp_gen: RTL and testbench

Complementary PWM source that produces the `highIn`/`lowIn` pair consumed by the non-overlap dead-time block downstream. A free-running period counter is compared against a double-buffered duty value to generate one high-side and one low-side request per period. New duty values arrive over a valid/ready handshake and take effect only at a period boundary. An enable with graceful drain stops the output only at the end of a complete period.

---
 rtl/pwm_comp_gen.sv | 118 +++++++++++
 tb/tb_pwm_comp_gen.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_comp_gen.sv
// Complementary PWM request generator: free-running period counter compared
// against a double-buffered duty value, with graceful drain on enable drop.
module pwm_comp_gen #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] duty,
    input  logic             duty_vld,
    output logic             duty_rdy,
    output logic             highIn,
    output logic             lowIn,
    output logic             period_start
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] active_duty;
    logic [CNT_W-1:0] pend_duty;
    logic             pend_vld;
    logic             shadow_load;
    logic             xfer;
    logic             at_max;
    logic             running;

    assign duty_rdy = !pend_vld;
    assign xfer     = duty_vld && !pend_vld;
    assign at_max   = (cnt == CNT_MAX);
    assign running  = (state != IDLE);

    // The shadow load is tied to every edge that sets cnt to 0, except the
    // final wrap of a drain, so a new duty always starts on a period boundary.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shadow_load = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    state_nxt   = RUN;
                    shadow_load = 1'b1;
                end
            end
            RUN: begin
                cnt_nxt = cnt + 1'b1;
                if (at_max) shadow_load = 1'b1;
                if (!en) state_nxt = DRAIN;
            end
            DRAIN: begin
                cnt_nxt = cnt + 1'b1;
                if (en) begin
                    state_nxt = RUN;
                    if (at_max) shadow_load = 1'b1;
                end else if (at_max) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A transfer coinciding with a shadow load becomes the new pending value
    // while the shadow takes the previous one; the later assignment wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_duty <= '0;
            pend_duty   <= '0;
            pend_vld    <= 1'b0;
        end else begin
            if (shadow_load) begin
                active_duty <= pend_duty;
                pend_vld    <= 1'b0;
            end
            if (xfer) begin
                pend_duty <= duty;
                pend_vld  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            highIn       <= 1'b0;
            lowIn        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            highIn       <= running && (cnt < active_duty);
            lowIn        <= running && !(cnt < active_duty);
            period_start <= running && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_comp_gen.sv
// Self-checking bench for pwm_comp_gen (CNT_W=4, period 16) using a
// cycle-position reference model plus scenario-level pulse-count checks.
module tb_pwm_comp_gen;

    localparam int W   = 4;
    localparam int PER = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] duty;
    logic         duty_vld;
    logic         duty_rdy;
    logic         highIn;
    logic         lowIn;
    logic         period_start;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_comp_gen #(.CNT_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .duty        (duty),
        .duty_vld    (duty_vld),
        .duty_rdy    (duty_rdy),
        .highIn      (highIn),
        .lowIn       (lowIn),
        .period_start(period_start)
    );

    // Reference: position within the period, live flag, and the duty values
    // in force / waiting; expected outputs describe the position just left.
    bit m_live = 0, m_stopping = 0, m_pvld = 0;
    int m_pos = 0, m_act = 0, m_pdut = 0;
    bit exp_high = 0, exp_low = 0, exp_ps = 0;

    always @(posedge clk or negedge rst_n) begin
        bit xfer;
        int nd;
        if (!rst_n) begin
            m_live = 0; m_stopping = 0; m_pvld = 0;
            m_pos = 0; m_act = 0; m_pdut = 0;
            exp_high = 0; exp_low = 0; exp_ps = 0;
        end else begin
            exp_high = m_live && (m_pos < m_act);
            exp_low  = m_live && !(m_pos < m_act);
            exp_ps   = m_live && (m_pos == 0);
            xfer = duty_vld && !m_pvld;
            nd   = int'(duty);
            if (!m_live) begin
                if (en) begin
                    m_live = 1; m_pos = 0; m_act = m_pdut; m_pvld = 0; m_stopping = 0;
                end
            end else if (m_pos == PER - 1) begin
                if (m_stopping && !en) begin
                    m_live = 0; m_pos = 0;
                end else begin
                    m_pos = 0; m_act = m_pdut; m_pvld = 0; m_stopping = !en;
                end
            end else begin
                m_pos = m_pos + 1;
                m_stopping = !en;
            end
            if (xfer) begin
                m_pdut = nd; m_pvld = 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic goto_pos(input int target, input string tag);
        int n = 0;
        while (!(m_live && m_pos == target) && n < 64) begin
            tick();
            n++;
        end
        total++;
        if (!(m_live && m_pos == target)) begin
            bad++;
            $display("FAIL %s_reach_pos: pos=%0d live=%0d required pos=%0d", tag, m_pos, m_live, target);
        end
    endtask

    task automatic offer(input logic [W-1:0] v, input string tag);
        int n = 0;
        duty = v;
        duty_vld = 1'b1;
        while (m_pvld && n < 64) begin
            tick();
            n++;
        end
        total++;
        if (m_pvld) begin
            bad++;
            $display("FAIL %s_offer_timeout: still not ready after %0d cycles", tag, n);
        end
        tick();
        duty_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; duty_vld = 1'b0; duty = '0;
        #12;
        total++;
        if ({highIn, lowIn, period_start, duty_rdy} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_hold: got %b required 0001", {highIn, lowIn, period_start, duty_rdy});
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if ({highIn, lowIn, period_start, duty_rdy} !== 4'b0001) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d got %b required 0001", i, {highIn, lowIn, period_start, duty_rdy});
            end
        end
    endtask

    task automatic test_basic();
        offer(W'(5), "basic");
        en = 1'b1;
        tick();
        total++;
        if (period_start !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency1: period_start=%b required 0", period_start);
        end
        tick();
        for (int i = 0; i < 3 * PER; i++) begin
            total++;
            if (highIn !== ((i % PER) < 5) || lowIn !== ((i % PER) >= 5) ||
                period_start !== ((i % PER) == 0) || (highIn && lowIn)) begin
                bad++;
                $display("FAIL basic_wave: i=%0d got h%b l%b p%b required h%b l%b p%b", i,
                         highIn, lowIn, period_start, (i % PER) < 5, (i % PER) >= 5, (i % PER) == 0);
            end
            tick();
        end
    endtask

    task automatic test_update();
        int hc1 = 0, hc2 = 0, n = 0;
        goto_pos(7, "update");
        duty = W'(12);
        duty_vld = 1'b1;
        total++;
        if (duty_rdy !== 1'b1) begin
            bad++;
            $display("FAIL update_first_rdy: duty_rdy=%b required 1", duty_rdy);
        end
        tick();
        duty = W'(9);
        while (m_pos != 0 && n < 20) begin
            total++;
            if (duty_rdy !== 1'b0 || {highIn, lowIn} !== {exp_high, exp_low}) begin
                bad++;
                $display("FAIL update_hold: pos=%0d got r%b h%b l%b required r0 h%b l%b",
                         m_pos, duty_rdy, highIn, lowIn, exp_high, exp_low);
            end
            tick();
            n++;
        end
        tick();
        duty_vld = 1'b0;
        for (int i = 0; i < 2 * PER; i++) begin
            total++;
            if ({highIn, lowIn, period_start, duty_rdy} !== {exp_high, exp_low, exp_ps, ~m_pvld}) begin
                bad++;
                $display("FAIL update_cycle: i=%0d got %b required %b", i,
                         {highIn, lowIn, period_start, duty_rdy}, {exp_high, exp_low, exp_ps, ~m_pvld});
            end
            if (i < PER) hc1 += int'(highIn); else hc2 += int'(highIn);
            tick();
        end
        total++;
        if (hc1 != 12 || hc2 != 9) begin
            bad++;
            $display("FAIL update_counts: high cycles %0d,%0d required 12,9", hc1, hc2);
        end
    endtask

    task automatic test_boundaries();
        int hc = 0, lc = 0, hc2 = 0;
        offer(W'(0), "dzero");
        goto_pos(0, "dzero");
        tick();
        for (int i = 0; i < PER; i++) begin
            hc += int'(highIn); lc += int'(lowIn);
            tick();
        end
        total++;
        if (hc != 0 || lc != PER) begin
            bad++;
            $display("FAIL duty0_counts: high=%0d low=%0d required 0 16", hc, lc);
        end
        offer(W'(15), "dmax");
        goto_pos(0, "dmax");
        tick();
        hc = 0; lc = 0;
        for (int i = 0; i < PER; i++) begin
            hc += int'(highIn); lc += int'(lowIn);
            tick();
        end
        total++;
        if (hc != 15 || lc != 1) begin
            bad++;
            $display("FAIL duty15_counts: high=%0d low=%0d required 15 1", hc, lc);
        end
        goto_pos(15, "wrapxfer");
        duty = W'(3);
        duty_vld = 1'b1;
        tick();
        duty_vld = 1'b0;
        tick();
        hc = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            total++;
            if ({highIn, lowIn, period_start} !== {exp_high, exp_low, exp_ps}) begin
                bad++;
                $display("FAIL wrapxfer_cycle: i=%0d got %b required %b", i,
                         {highIn, lowIn, period_start}, {exp_high, exp_low, exp_ps});
            end
            if (i < PER) hc += int'(highIn); else hc2 += int'(highIn);
            tick();
        end
        total++;
        if (hc != 15 || hc2 != 3) begin
            bad++;
            $display("FAIL wrapxfer_counts: high cycles %0d,%0d required 15,3", hc, hc2);
        end
    endtask

    task automatic test_drain();
        int act = 0, phase = 0, n = 0;
        bit last_low = 0;
        goto_pos(3, "drain");
        en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if ({highIn, lowIn, period_start} !== {exp_high, exp_low, exp_ps}) begin
                bad++;
                $display("FAIL drain_cycle: i=%0d got %b required %b", i,
                         {highIn, lowIn, period_start}, {exp_high, exp_low, exp_ps});
            end
            if (highIn || lowIn) begin
                act++;
                last_low = lowIn;
            end
        end
        total++;
        if (act != 13 || !last_low || highIn || lowIn) begin
            bad++;
            $display("FAIL drain_stop: active=%0d last_low=%0d h%b l%b required 13 1 h0 l0",
                     act, last_low, highIn, lowIn);
        end
        en = 1'b1;
        while (!period_start && n < 8) begin
            tick();
            n++;
        end
        for (int i = 0; i < 4 * PER; i++) begin
            total++;
            if (period_start !== ((i % PER) == 0) || (highIn === lowIn)) begin
                bad++;
                $display("FAIL toggle_spacing: i=%0d got p%b h%b l%b required p%b one-hot",
                         i, period_start, highIn, lowIn, (i % PER) == 0);
            end
            if (phase == 0 && m_pos == 3) begin
                en = 1'b0; phase = 1;
            end else if (phase == 1 && m_pos == 9) begin
                en = 1'b1; phase = 2;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int lc = 0;
        offer(W'(7), "rstmid_a");
        goto_pos(5, "rstmid");
        offer(W'(10), "rstmid_b");
        goto_pos(8, "rstmid");
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({highIn, lowIn, period_start, duty_rdy} !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_async: got %b required 0001", {highIn, lowIn, period_start, duty_rdy});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        for (int i = 0; i < PER; i++) begin
            total++;
            if ({highIn, lowIn, period_start} !== {1'b0, 1'b1, i == 0}) begin
                bad++;
                $display("FAIL rstmid_period: i=%0d got %b required 01%b", i,
                         {highIn, lowIn, period_start}, i == 0);
            end
            lc += int'(lowIn);
            tick();
        end
        total++;
        if (lc != PER) begin
            bad++;
            $display("FAIL rstmid_lowcount: low=%0d required 16", lc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            tick();
            total++;
            if ({highIn, lowIn, period_start, duty_rdy} !== {exp_high, exp_low, exp_ps, ~m_pvld}) begin
                bad++;
                $display("FAIL random_cycle: i=%0d got %b required %b", i,
                         {highIn, lowIn, period_start, duty_rdy}, {exp_high, exp_low, exp_ps, ~m_pvld});
            end
            if ($urandom_range(0, 39) == 0) en = ~en;
            if (!duty_vld || !m_pvld) begin
                duty     = W'($urandom);
                duty_vld = ($urandom_range(0, 3) == 0);
            end
        end
        en = 1'b0;
        duty_vld = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        total++;
        if ({highIn, lowIn, period_start} !== 3'b000 || m_live) begin
            bad++;
            $display("FAIL random_final_idle: got %b live=%0d required 000 live=0",
                     {highIn, lowIn, period_start}, m_live);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_update();
        test_boundaries();
        test_drain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
